// File: rtl/fixed_acc_drain.sv
// fixed_acc_drain
//   Drain stage for a multiply-accumulate datapath. Gates operand beats into an
//   external MAC, feeds the accumulator back (or zero at the start of a vector),
//   captures the final dot-product sum, and requantises it into a signed
//   OUT_SIZE-bit result. The result is offered on a valid/ready output.
//
// Parameters
//   ACC_DESIRED : accumulator width (matches the MAC stage)
//   OUT_SIZE    : signed output width
//   SHIFT       : right-shift for requantisation, 0..ACC_DESIRED-2
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   inValid, inLast       : upstream beat present / beat ends its vector
//   inReady               : block accepts a beat this cycle
//   opEnable              : beat accepted this cycle (MAC operands live)
//   accOut                : registered MAC result
//   accIn                 : feedback operand to the MAC
//   outValid, outReady    : output handshake
//   outData, outSat       : requantised result and clamp flag
module fixed_acc_drain #(
  parameter int ACC_DESIRED = 32,
  parameter int OUT_SIZE    = 8,
  parameter int SHIFT       = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          inValid,
  input  logic                          inLast,
  output logic                          inReady,
  output logic                          opEnable,
  input  logic signed [ACC_DESIRED-1:0] accOut,
  output logic signed [ACC_DESIRED-1:0] accIn,
  output logic                          outValid,
  input  logic                          outReady,
  output logic signed [OUT_SIZE-1:0]    outData,
  output logic                          outSat
);

  localparam logic signed [ACC_DESIRED:0] ONE  = {{ACC_DESIRED{1'b0}}, 1'b1};
  // Half an LSB of the shifted result; zero when SHIFT is zero.
  localparam logic signed [ACC_DESIRED:0] RND  = (ONE << SHIFT) >> 1;
  localparam logic signed [ACC_DESIRED:0] MAXV = (ONE << (OUT_SIZE - 1)) - ONE;
  localparam logic signed [ACC_DESIRED:0] MINV = -(ONE << (OUT_SIZE - 1));

  logic                          first_q, first_d;
  logic                          pend_q, pend_d;
  logic                          capValid_q, capValid_d;
  logic signed [ACC_DESIRED-1:0] cap_q, cap_d;
  logic                          outValid_q, outValid_d;
  logic signed [OUT_SIZE-1:0]    outData_q, outData_d;
  logic                          outSat_q, outSat_d;

  logic                          accept;
  logic                          transfer;
  logic signed [ACC_DESIRED:0]   r;
  logic signed [ACC_DESIRED:0]   q;
  logic signed [OUT_SIZE-1:0]    qData;
  logic                          qSat;

  always_comb begin
    inReady  = !(capValid_q && outValid_q && !outReady);
    accept   = inValid && inReady;
    opEnable = accept;
    accIn    = first_q ? '0 : accOut;
    transfer = capValid_q && (!outValid_q || outReady);
  end

  // Requantisation of the capture register, one bit wider than the accumulator
  // so the rounding add cannot overflow.
  always_comb begin
    r     = {cap_q[ACC_DESIRED-1], cap_q} + RND;
    q     = r >>> SHIFT;
    qData = q[OUT_SIZE-1:0];
    qSat  = 1'b0;
    if (q > MAXV) begin
      qData = MAXV[OUT_SIZE-1:0];
      qSat  = 1'b1;
    end else if (q < MINV) begin
      qData = MINV[OUT_SIZE-1:0];
      qSat  = 1'b1;
    end
  end

  always_comb begin
    first_d    = first_q;
    pend_d     = 1'b0;
    cap_d      = cap_q;
    capValid_d = capValid_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outSat_d   = outSat_q;

    if (accept) begin
      first_d = inLast;
    end
    // The MAC registers the final sum on the edge that accepts the last beat,
    // so the capture happens one edge later via this pending flag.
    pend_d = accept && inLast;

    if (transfer) begin
      capValid_d = 1'b0;
    end
    if (pend_q) begin
      cap_d      = accOut;
      capValid_d = 1'b1;
    end

    if (transfer) begin
      outValid_d = 1'b1;
      outData_d  = qData;
      outSat_d   = qSat;
    end else if (outReady) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      first_q    <= 1'b1;
      pend_q     <= 1'b0;
      cap_q      <= '0;
      capValid_q <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outSat_q   <= 1'b0;
    end else begin
      first_q    <= first_d;
      pend_q     <= pend_d;
      cap_q      <= cap_d;
      capValid_q <= capValid_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outSat_q   <= outSat_d;
    end
  end

  assign outValid = outValid_q;
  assign outData  = outData_q;
  assign outSat   = outSat_q;

endmodule
